// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between a load/store initiator and the data memory.
interface dmem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_WIDTH  = 31
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic [RAM_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: byte-lane data memory with a valid/ready request port, fixed wait
// states and a held response; rejects misaligned, out-of-range and reserved-size accesses.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_WIDTH   = 31,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input logic clk,
    input logic rst,
    dmem_if.slave bus
);
    localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LANES = DATA_WIDTH / 8;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic we;
    logic [1:0] size;
    logic [RAM_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata, rdata, word, ld, rd_sel, wd;
    logic err_q, err, accept, commit;
    logic [RAM_WIDTH-3:0] idx;
    logic [1:0] off;
    logic [AW-1:0] wi;
    logic [LANES-1:0] be;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    assign idx    = addr[RAM_WIDTH-1:2];
    assign off    = addr[1:0];
    assign wi     = idx[AW-1:0];
    assign accept = bus.req_valid && bus.req_ready;
    assign commit = state == ACCESS && cnt == 4'd0;
    assign err    = size == 2'd3 || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0)
                    || 32'(idx) >= 32'(DEPTH);
    assign word   = mem[wi];
    assign ld     = word >> {off, 3'b000};
    assign rd_sel = size == 2'd0 ? DATA_WIDTH'(ld[7:0]) : size == 2'd1 ? DATA_WIDTH'(ld[15:0]) : ld;
    // Replicate store data across lanes so the byte enables alone pick the target bytes.
    assign be     = size == 2'd0 ? LANES'(1) << off : size == 2'd1 ? LANES'(3) << {off[1], 1'b0} : '1;
    assign wd     = size == 2'd0 ? {LANES{wdata[7:0]}} : size == 2'd1 ? {(LANES/2){wdata[15:0]}} : wdata;
    assign bus.req_ready  = state == IDLE && !rst;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_rdata = state == RESP ? rdata : '0;
    assign bus.resp_err   = state == RESP && err_q;
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (accept ? ACCESS : IDLE)
                 : state == ACCESS ? (cnt == 4'd0 ? RESP : ACCESS)
                 : (bus.resp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= accept ? 4'(WAIT_CYCLES) : (state == ACCESS && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            if (commit) begin
                err_q <= err;
                rdata <= (err || we) ? '0 : rd_sel;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            we    <= bus.req_we;
            size  <= bus.req_size;
            addr  <= bus.req_addr;
            wdata <= bus.req_wdata;
        end
    end
    // Memory is never reset; an aborted access never reaches the commit edge.
    always_ff @(posedge clk) begin
        if (commit && we && !err)
            for (int i = 0; i < LANES; i++)
                if (be[i]) mem[wi][8*i +: 8] <= wd[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random loads/stores checked against a byte-addressed memory model.
module tb_dmem_responder;
    localparam int W     = 1;
    localparam int DEPTH = 1024;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] mb [4*DEPTH];
    dmem_if #(.DATA_WIDTH(32), .RAM_WIDTH(31)) bus ();
    dmem_responder #(.DATA_WIDTH(32), .RAM_WIDTH(31), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Byte-addressed little-endian view of memory: an access touches 2**size consecutive bytes.
    function automatic void model(input logic we, input logic [1:0] sz, input int unsigned a,
                                  input logic [31:0] wdat, output logic [31:0] rd, output logic er);
        int unsigned n = 1 << sz;
        er = sz == 2'd3 || a % n != 0 || a / 4 >= DEPTH;
        rd = 32'h0;
        if (!er)
            for (int k = 0; k < int'(n); k++)
                if (we) mb[a+k] = wdat[8*k +: 8];
                else rd[8*k +: 8] = mb[a+k];
    endfunction
    task automatic do_req(input logic we, input logic [1:0] sz, input int unsigned a,
                          input logic [31:0] wdat, input int hold, output logic [31:0] obs, output logic oerr);
        logic [31:0] erd, held;
        logic eer, rdy;
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_addr = 31'(a); bus.req_wdata = wdat; bus.resp_ready = hold == 0;
        n = 0;
        do begin
            rdy = bus.req_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 20);
        check("accept", 32'(rdy), 32'h1);
        #1;
        bus.req_valid = 1'b0;
        model(we, sz, a, wdat, erd, eer);
        n = 1;
        while (!bus.resp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, W + 2);
        if (hold > 0) begin
            held = bus.resp_rdata;
            bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
            bus.req_addr = 31'h0; bus.req_wdata = $urandom;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check("hold_valid", 32'(bus.resp_valid), 32'h1);
                check("hold_rdata", bus.resp_rdata, held);
                check("hold_ready", 32'(bus.req_ready), 32'h0);
            end
            bus.req_valid = 1'b0;
            bus.resp_ready = 1'b1;
        end
        obs = bus.resp_rdata;
        oerr = bus.resp_err;
        check("rdata", obs, erd);
        check("err", 32'(oerr), 32'(eer));
        @(posedge clk);
        #1;
        check("idle_ready", 32'(bus.req_ready), 32'h1);
        check("idle_valid", 32'(bus.resp_valid), 32'h0);
    endtask
    initial begin
        logic [31:0] r;
        logic e;
        int unsigned a;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
        #12;
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_err", 32'(bus.resp_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'h1);
        for (int i = 0; i < 16; i++) do_req(1'b1, 2'd2, 4 * i, $urandom, 0, r, e);
        do_req(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 0, r, e);
        check("sw_rdata0", r, 32'h0);
        do_req(1'b0, 2'd2, 32'h10, 32'h0, 0, r, e);
        check("lw_10", r, 32'hDEADBEEF);
        check("lw_10_err", 32'(e), 32'h0);
        do_req(1'b1, 2'd0, 32'h12, 32'h55, 0, r, e);
        do_req(1'b0, 2'd2, 32'h10, 32'h0, 0, r, e);
        check("lw_after_sb", r, 32'hDE55BEEF);
        do_req(1'b0, 2'd1, 32'h12, 32'h0, 0, r, e);
        check("lh_12", r, 32'h0000DE55);
        do_req(1'b0, 2'd0, 32'h13, 32'h0, 0, r, e);
        check("lb_13", r, 32'h000000DE);
        do_req(1'b1, 2'd1, 32'h11, 32'hFFFF, 0, r, e);
        check("sh_11_err", 32'(e), 32'h1);
        do_req(1'b0, 2'd2, 32'h10, 32'h0, 0, r, e);
        check("lw_unchanged", r, 32'hDE55BEEF);
        do_req(1'b0, 2'd2, 32'h12, 32'h0, 0, r, e);
        check("lw_12_err", 32'(e), 32'h1);
        check("lw_12_rdata", r, 32'h0);
        do_req(1'b0, 2'd3, 32'h10, 32'h0, 0, r, e);
        check("size3_err", 32'(e), 32'h1);
        do_req(1'b0, 2'd2, 4 * DEPTH, 32'h0, 0, r, e);
        check("oor_err", 32'(e), 32'h1);
        do_req(1'b1, 2'd2, 4 * DEPTH, 32'hA5A5A5A5, 0, r, e);
        do_req(1'b0, 2'd2, 32'h0, 32'h0, 0, r, e);
        do_req(1'b0, 2'd2, 32'h10, 32'h0, 5, r, e);
        check("held_lw", r, 32'hDE55BEEF);
        do_req(1'b0, 2'd2, 32'h0, 32'h0, 0, r, e);
        // Reset in the first access cycle of a store: the store must be dropped.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_addr = 31'h20; bus.req_wdata = 32'h12345678; bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(bus.req_ready), 32'h0);
        check("abort_valid", 32'(bus.resp_valid), 32'h0);
        check("abort_rdata", bus.resp_rdata, 32'h0);
        check("abort_err", 32'(bus.resp_err), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_post_ready", 32'(bus.req_ready), 32'h1);
        do_req(1'b0, 2'd2, 32'h20, 32'h0, 0, r, e);
        for (int i = 0; i < 200; i++) begin
            a = $urandom_range(0, 9) == 0 ? 4 * DEPTH + $urandom_range(0, 15) : $urandom_range(0, 63);
            do_req(1'($urandom), 2'($urandom), a, $urandom, $urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0, r, e);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
